pc_gen: RTL and testbench
=========================

# pc_gen

Parametrised fetch-address generator for the pipelined MIPS core, replacing the plain PC register in the IF stage. It holds the fetch PC and advances it by `STEP` when the instruction-memory request is accepted. It takes exception flushes and branch redirects, and keeps a redirect that arrives while fetch cannot advance. It drives the instruction SRAM request and flags misaligned fetch addresses (AdEL) for the exception unit.

## Interface
Parameters:
- `WIDTH`, 32: PC width in bits; legal values ≥ 3.
- `RESET_PC`, 32'hbfc00000: value loaded on reset, truncated to `WIDTH`.
- `STEP`, 4: sequential increment in bytes.

Ports:
- `clk` input 1: single clock; all state updates on its rising edge.
- `rst` input 1: synchronous, active-high reset.
- `stall` input 1: pipeline stall from hazard unit; blocks advance.
- `flush` input 1: exception/ERET redirect; highest priority after `rst`.
- `flush_pc` input WIDTH: flush target (exception vector or EPC).
- `br_taken` input 1: branch/jump resolved taken.
- `br_target` input WIDTH: branch/jump target.
- `req_ok` input 1: instruction SRAM accepted the current request (addr_ok).
- `pc` output WIDTH: current fetch address (register).
- `req` output 1: fetch request valid, `pc_valid & ~stall`.
- `pc_valid` output 1: `pc` holds a fetchable address (register).
- `adel` output 1: `pc_valid & (pc[1:0] != 0)`, combinational.
- `redir_pend` output 1: a branch redirect is latched and waiting (register).

## Operation
- Advance condition: `adv = pc_valid & ~stall & req_ok`.
- State machine over `{pc_valid, redir_pend}`:
  - RESET: `pc_valid=0`.
  - RUN: `pc_valid=1`, `redir_pend=0`.
  - PEND: `pc_valid=1`, `redir_pend=1`.
- Per-cycle priority, first match wins:
  1. `rst`: `pc<=RESET_PC`, `pc_valid<=0`, `redir_pend<=0`, pending target cleared to 0.
  2. RESET state without `rst`: `pc_valid<=1`, `pc` unchanged. All other inputs are ignored this cycle.
  3. `flush`: `pc<=flush_pc` and `redir_pend<=0`, regardless of `stall`/`req_ok`. Any pending branch is discarded and `br_taken` in the same cycle is ignored.
  4. `br_taken & adv`: `pc<=br_target`, `redir_pend<=0`. A new branch outranks an older pending one.
  5. `br_taken & ~adv`: `pend_target<=br_target`, `redir_pend<=1`, `pc` held. A new branch overwrites an earlier pending target.
  6. `redir_pend & adv`: `pc<=pend_target`, `redir_pend<=0`.
  7. `adv`: `pc<=pc+STEP`, modulo 2^WIDTH; wraps from all-ones region to low addresses with no flag.
  8. Otherwise all state holds.
- `adel` does not stop advance. The exception unit is responsible for raising `flush`.
- `req` is low in RESET and while `stall`=1. `req_ok` is ignored when `req`=0.

## Timing
- Reset values: `pc=RESET_PC`, `pc_valid=0`, `redir_pend=0`, `req=0`, `adel=0`.
- First request: `req=1` in the second cycle after `rst` deasserts, provided `stall`=0.
- Redirect latency:
  - `flush` or taken branch with `adv`: new `pc` visible one cycle after the input edge.
  - Pending branch: applied on the edge of the first cycle with `adv`=1.
- `rst` asserted mid-operation (including in PEND) wins over every other input on that edge.
- Simultaneous `flush` and `br_taken`: flush target taken, nothing latched.
- Simultaneous `stall` and `flush`: flush still applies; `pc` changes while stalled.
- Outputs `pc`, `pc_valid`, `redir_pend` are registered. `req` and `adel` are combinational from registers plus `stall` only, with no path from `req_ok` or `br_*`.

## Test plan
- Reset/boot: hold `rst` 3 cycles, release, keep `stall`=0, `req_ok`=1.
  - Expect `pc`=bfc00000 with `req`=0 the first cycle after release.
  - Then `req`=1 and `pc`=bfc00000, bfc00004, bfc00008 on consecutive cycles.
- Stall/backpressure:
  - At `pc`=bfc00010, set `stall`=1 for 2 cycles → `pc` holds, `req`=0.
  - Then `req_ok`=0 for 2 cycles → `pc` holds, `req`=1.
  - Then `req_ok`=1 → next `pc`=bfc00014.
- Pending branch:
  - `br_taken`=1, `br_target`=bfc00100 with `req_ok`=0 → `redir_pend`=1, `pc` unchanged.
  - A second branch to bfc00200 while still pending overwrites the target.
  - `req_ok`=1 → `pc`=bfc00200, `redir_pend`=0.
- Flush priority:
  - While in PEND with `stall`=1, assert `flush` with `flush_pc`=bfc00380 and `br_taken`=1 → next `pc`=bfc00380, `redir_pend`=0.
- Misalign and wrap, with `WIDTH`=32:
  - `flush_pc`=bfc00382 → `adel`=1 the following cycle.
  - `flush_pc`=fffffffc then advance → `pc`=00000000.
- Reset mid-pending:
  - `rst` asserted while `redir_pend`=1 and `br_taken`=1 → `pc`=bfc00000, `pc_valid`=0, `redir_pend`=0.
  - After release, the first advance yields bfc00004, with no stale target.

Source files
------------

// File: rtl/pc_gen.sv
// Fetch-address generator for the IF stage: holds the fetch PC, applies flush/branch redirects.
// Latency: pc, pc_valid, redir_pend registered (1 cycle); req and adel combinational from state + stall.
// Backpressure: stall or a refused request (req_ok=0) holds pc; a taken branch arriving then is parked.
module pc_gen #(
   parameter int          WIDTH    = 32,
   parameter logic [31:0] RESET_PC = 32'hbfc00000,
   parameter int          STEP     = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             stall,
   input  logic             flush,
   input  logic [WIDTH-1:0] flush_pc,
   input  logic             br_taken,
   input  logic [WIDTH-1:0] br_target,
   input  logic             req_ok,
   output logic [WIDTH-1:0] pc,
   output logic             req,
   output logic             pc_valid,
   output logic             adel,
   output logic             redir_pend
);

   // State encoding is {pc_valid, redir_pend}, so the outputs fall straight out of it.
   localparam logic [1:0] ST_RESET = 2'b00;
   localparam logic [1:0] ST_RUN   = 2'b10;
   localparam logic [1:0] ST_PEND  = 2'b11;

   localparam logic [WIDTH-1:0] RST_PC_W = WIDTH'(RESET_PC);
   localparam logic [WIDTH-1:0] STEP_W   = WIDTH'(STEP);

   logic [1:0]       state_q;
   logic [1:0]       state_d;
   logic [WIDTH-1:0] pc_q;
   logic [WIDTH-1:0] pc_d;
   logic [WIDTH-1:0] pend_target_q;
   logic [WIDTH-1:0] pend_target_d;
   logic             adv;

   assign pc_valid   = state_q[1];
   assign redir_pend = state_q[1] & state_q[0];
   assign pc         = pc_q;

   // Request is offered whenever the PC is fetchable and the pipe is not stalled;
   // req_ok only matters while req is high.
   assign req = pc_valid & ~stall;
   assign adv = req & req_ok;

   // Misaligned fetch is only flagged; the exception unit decides to flush.
   assign adel = pc_valid & (pc_q[1:0] != 2'b00);

   // Next-state selection: first matching redirect source wins.
   always_comb begin
      state_d       = state_q;
      pc_d          = pc_q;
      pend_target_d = pend_target_q;
      case (state_q)
         ST_RESET: begin
            // One idle cycle after reset to make the boot PC fetchable; inputs ignored.
            state_d = ST_RUN;
         end
         ST_RUN, ST_PEND: begin
            if (flush) begin
               // Exception/ERET redirect discards any parked branch, even while stalled.
               pc_d    = flush_pc;
               state_d = ST_RUN;
            end else if (br_taken && adv) begin
               // A fresh branch supersedes an older parked one.
               pc_d    = br_target;
               state_d = ST_RUN;
            end else if (br_taken) begin
               // Cannot advance: park the newest target until the request is accepted.
               pend_target_d = br_target;
               state_d       = ST_PEND;
            end else if ((state_q == ST_PEND) && adv) begin
               pc_d    = pend_target_q;
               state_d = ST_RUN;
            end else if (adv) begin
               // Wraps modulo 2^WIDTH with no indication.
               pc_d = pc_q + STEP_W;
            end
         end
         default: begin
            // Unreachable encoding; recover to a fetchable state at the current PC.
            state_d = ST_RUN;
         end
      endcase
   end

   // State registers with synchronous active-high reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= ST_RESET;
         pc_q          <= RST_PC_W;
         pend_target_q <= '0;
      end else begin
         state_q       <= state_d;
         pc_q          <= pc_d;
         pend_target_q <= pend_target_d;
      end
   end

endmodule

// File: tb/tb_pc_gen.sv
// Bench for pc_gen: directed boot/stall/redirect/wrap scenarios, then random traffic.
// Latency: model updated on every rising edge, outputs compared mid-cycle.
// Backpressure: stall and req_ok are driven directly by the stimulus.
module tb_pc_gen;

   localparam int WIDTH = 32;

   logic             clk = 1'b0;
   logic             rst;
   logic             stall;
   logic             flush;
   logic [WIDTH-1:0] flush_pc;
   logic             br_taken;
   logic [WIDTH-1:0] br_target;
   logic             req_ok;
   logic [WIDTH-1:0] pc;
   logic             req;
   logic             pc_valid;
   logic             adel;
   logic             redir_pend;

   int checks   = 0;
   int failures = 0;

   // Reference model: boot flag, fetch pc, and a queue holding at most one parked branch target.
   logic [31:0] m_pc;
   bit          m_booted;
   logic [31:0] m_parked[$];

   pc_gen #(.WIDTH(WIDTH), .RESET_PC(32'hbfc00000), .STEP(4)) dut (
      .clk        (clk),
      .rst        (rst),
      .stall      (stall),
      .flush      (flush),
      .flush_pc   (flush_pc),
      .br_taken   (br_taken),
      .br_target  (br_target),
      .req_ok     (req_ok),
      .pc         (pc),
      .req        (req),
      .pc_valid   (pc_valid),
      .adel       (adel),
      .redir_pend (redir_pend)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // Expected outputs straight from the model state.
   task automatic compare_all();
      bit fetchable;
      fetchable = m_booted;
      chk("pc", pc, m_pc);
      chk("pc_valid", {31'b0, pc_valid}, {31'b0, fetchable});
      chk("redir_pend", {31'b0, redir_pend}, {31'b0, (m_parked.size() != 0)});
      chk("req", {31'b0, req}, {31'b0, fetchable && !stall});
      chk("adel", {31'b0, adel}, {31'b0, fetchable && (m_pc % 4 != 0)});
   endtask

   // One clock edge of the model, following the redirect priority list.
   task automatic model_edge();
      bit go;
      go = m_booted && !stall && req_ok;
      if (rst) begin
         m_pc     = 32'hbfc00000;
         m_booted = 0;
         m_parked.delete();
      end else if (!m_booted) begin
         m_booted = 1;
      end else if (flush) begin
         m_pc = flush_pc;
         m_parked.delete();
      end else if (br_taken) begin
         m_parked.delete();
         if (go) m_pc = br_target;
         else    m_parked.push_back(br_target);
      end else if (go) begin
         if (m_parked.size() != 0) m_pc = m_parked.pop_front();
         else                      m_pc = (m_pc + 4) & 32'hffffffff;
      end
   endtask

   // Settle, compare, clock, advance the model.
   task automatic tick();
      #1;
      compare_all();
      @(posedge clk);
      model_edge();
      #1;
   endtask

   task automatic idle_inputs();
      rst = 0; stall = 0; flush = 0; flush_pc = '0;
      br_taken = 0; br_target = '0; req_ok = 1;
   endtask

   initial begin
      m_pc = 32'hbfc00000;
      m_booted = 0;
      idle_inputs();
      rst = 1;
      @(posedge clk); model_edge(); #1;
      repeat (3) tick();
      chk("reset_pc", pc, 32'hbfc00000);
      chk("reset_req", {31'b0, req}, 32'd0);
      chk("reset_adel", {31'b0, adel}, 32'd0);

      // Boot: one idle cycle, then sequential fetch.
      rst = 0;
      #1;
      chk("boot_req0", {31'b0, req}, 32'd0);
      chk("boot_pc0", pc, 32'hbfc00000);
      tick();
      chk("boot_req1", {31'b0, req}, 32'd1);
      chk("boot_pc1", pc, 32'hbfc00000);
      tick();
      chk("boot_pc2", pc, 32'hbfc00004);
      tick();
      chk("boot_pc3", pc, 32'hbfc00008);
      tick(); tick();
      chk("at_10", pc, 32'hbfc00010);

      // Stall, then refused requests, then acceptance.
      stall = 1;
      tick(); tick();
      chk("stall_pc", pc, 32'hbfc00010);
      #1 chk("stall_req", {31'b0, req}, 32'd0);
      stall = 0; req_ok = 0;
      tick(); tick();
      chk("nok_pc", pc, 32'hbfc00010);
      #1 chk("nok_req", {31'b0, req}, 32'd1);
      req_ok = 1;
      tick();
      chk("resume_pc", pc, 32'hbfc00014);

      // Parked branch overwritten by a newer one, then applied.
      req_ok = 0; br_taken = 1; br_target = 32'hbfc00100;
      tick();
      chk("pend_set", {31'b0, redir_pend}, 32'd1);
      chk("pend_pc", pc, 32'hbfc00014);
      br_target = 32'hbfc00200;
      tick();
      br_taken = 0; req_ok = 1;
      tick();
      chk("pend_apply_pc", pc, 32'hbfc00200);
      chk("pend_clear", {31'b0, redir_pend}, 32'd0);

      // Flush beats stall, parked branch and same-cycle branch.
      req_ok = 0; br_taken = 1; br_target = 32'hbfc00300;
      tick();
      stall = 1; flush = 1; flush_pc = 32'hbfc00380; br_target = 32'hbfc00999;
      tick();
      chk("flush_pc", pc, 32'hbfc00380);
      chk("flush_pend", {31'b0, redir_pend}, 32'd0);

      // Misaligned target flags adel; wrap at the top of the address space.
      stall = 0; br_taken = 0; flush_pc = 32'hbfc00382;
      tick();
      #1 chk("adel_set", {31'b0, adel}, 32'd1);
      flush_pc = 32'hfffffffc;
      tick();
      flush = 0; req_ok = 1;
      tick();
      chk("wrap_pc", pc, 32'h00000000);

      // Reset while a branch is parked and another arrives.
      req_ok = 0; br_taken = 1; br_target = 32'hbfc00500;
      tick();
      rst = 1;
      tick();
      chk("rst_mid_pc", pc, 32'hbfc00000);
      chk("rst_mid_valid", {31'b0, pc_valid}, 32'd0);
      chk("rst_mid_pend", {31'b0, redir_pend}, 32'd0);
      idle_inputs();
      tick(); tick();
      chk("rst_mid_adv", pc, 32'hbfc00004);

      // Random traffic against the model.
      for (int i = 0; i < 3000; i++) begin
         rst       = ($urandom_range(0, 99) == 0);
         stall     = ($urandom_range(0, 3) == 0);
         req_ok    = ($urandom_range(0, 2) != 0);
         flush     = ($urandom_range(0, 15) == 0);
         br_taken  = ($urandom_range(0, 5) == 0);
         flush_pc  = $urandom() & (($urandom_range(0, 7) == 0) ? 32'hffffffff : 32'hfffffffc);
         br_target = $urandom() & 32'hfffffffc;
         tick();
      end
      idle_inputs();
      tick();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
